// File: rtl/otg_hpi_bridge.sv
// Avalon-MM slave that runs one timed HPI bus cycle to the CY7C67200 per request.
// Optional macro HPI_IRQ_SYNC_EN adds a synchronised OTG interrupt (otg_int -> irq, status bit 15).
module otg_hpi_bridge #(
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned STROBE_CYC  = 4,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [15:0] avs_writedata,
   output logic [15:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [1:0]  hpi_addr,
   output logic [15:0] hpi_data_out,
   output logic        hpi_data_oe,
   input  logic [15:0] hpi_data_in,
   output logic        hpi_cs_n,
   output logic        hpi_rd_n,
   output logic        hpi_wr_n
`ifdef HPI_IRQ_SYNC_EN
   ,
   input  logic        otg_int,
   output logic        irq
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_RECOVER
   } state_t;

   localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOVER_LD = (RECOVER_CYC == 0) ? 4'd0 : 4'(RECOVER_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        is_wr_q, is_wr_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] rd_capture;

`ifdef HPI_IRQ_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = otg_int;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign irq = sync2_q;

   // Status register reads carry the synchronised interrupt in bit 15.
   always_comb begin
      rd_capture = hpi_data_in;
      if (addr_q == 2'd3) begin
         rd_capture[15] = hpi_data_in[15] | sync2_q;
      end
   end
`else
   assign rd_capture = hpi_data_in;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (avs_read || avs_write) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               addr_d  = avs_address;
               wdata_d = avs_writedata;
               is_wr_d = avs_write;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               if (!is_wr_q) begin
                  rdata_d = rd_capture;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;
               cnt_d   = RECOVER_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      hpi_cs_n        = 1'b1;
      hpi_rd_n        = 1'b1;
      hpi_wr_n        = 1'b1;
      hpi_data_oe     = 1'b0;
      hpi_addr        = addr_q;
      hpi_data_out    = wdata_q;
      avs_readdata    = rdata_q;
      avs_waitrequest = (avs_read | avs_write) & ~((state_q == ST_HOLD) && (cnt_q == 4'd0));
      case (state_q)
         ST_SETUP, ST_HOLD: begin
            hpi_cs_n    = 1'b0;
            hpi_data_oe = is_wr_q;
         end
         ST_STROBE: begin
            hpi_cs_n    = 1'b0;
            hpi_data_oe = is_wr_q;
            hpi_rd_n    = is_wr_q;
            hpi_wr_n    = ~is_wr_q;
         end
         default: begin
            hpi_cs_n = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_otg_hpi_bridge.sv
// Directed bench for otg_hpi_bridge with default timing; cycle 0 is the request cycle in IDLE.
module tb_otg_hpi_bridge;

   logic        clk;
   logic        reset_n;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [15:0] avs_writedata;
   logic [15:0] avs_readdata;
   logic        avs_waitrequest;
   logic [1:0]  hpi_addr;
   logic [15:0] hpi_data_out;
   logic        hpi_data_oe;
   logic [15:0] hpi_data_in;
   logic        hpi_cs_n;
   logic        hpi_rd_n;
   logic        hpi_wr_n;
`ifdef HPI_IRQ_SYNC_EN
   logic        otg_int;
   logic        irq;
`endif

   int unsigned total;
   int unsigned bad;

   otg_hpi_bridge #(
      .SETUP_CYC  (1),
      .STROBE_CYC (4),
      .HOLD_CYC   (2),
      .RECOVER_CYC(2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .avs_address    (avs_address),
      .avs_read       (avs_read),
      .avs_write      (avs_write),
      .avs_writedata  (avs_writedata),
      .avs_readdata   (avs_readdata),
      .avs_waitrequest(avs_waitrequest),
      .hpi_addr       (hpi_addr),
      .hpi_data_out   (hpi_data_out),
      .hpi_data_oe    (hpi_data_oe),
      .hpi_data_in    (hpi_data_in),
      .hpi_cs_n       (hpi_cs_n),
      .hpi_rd_n       (hpi_rd_n),
      .hpi_wr_n       (hpi_wr_n)
`ifdef HPI_IRQ_SYNC_EN
      ,
      .otg_int        (otg_int),
      .irq            (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Cycles 0..7 of one access; returns at the cycle-7 sample point (request just accepted).
   task automatic access(input logic rd, input logic wr, input logic [1:0] a, input logic [15:0] d,
                         input logic [15:0] pin, input logic [15:0] rd_prev, input logic [15:0] rd_new);
      logic rd_only;
      rd_only = rd & ~wr;
      for (int c = 0; c <= 7; c++) begin
         if (c > 0) @(negedge clk);
         avs_read      = rd;
         avs_write     = wr;
         avs_address   = a;
         avs_writedata = d;
         hpi_data_in   = (c >= 2 && c <= 5) ? pin : 16'h0000;
         #1;
         chk1("cs_n", hpi_cs_n, (c >= 1) ? 1'b0 : 1'b1);
         chk1("rd_n", hpi_rd_n, (rd_only && c >= 2 && c <= 5) ? 1'b0 : 1'b1);
         chk1("wr_n", hpi_wr_n, (wr && c >= 2 && c <= 5) ? 1'b0 : 1'b1);
         chk1("data_oe", hpi_data_oe, (wr && c >= 1) ? 1'b1 : 1'b0);
         chk1("waitrequest", avs_waitrequest, (c == 7) ? 1'b0 : 1'b1);
         chk16("readdata", avs_readdata, (rd_only && c >= 6) ? rd_new : rd_prev);
         if (c >= 1) chk16("hpi_addr", {14'd0, hpi_addr}, {14'd0, a});
         if (wr && c >= 1) chk16("data_out", hpi_data_out, d);
      end
   endtask

   // Cycles 8..9 (RECOVER) with the next request already presented; ends at the IDLE cycle.
   task automatic gap(input logic nr, input logic nw, input logic [1:0] na, input logic [15:0] nd,
                      input logic [15:0] rd_exp);
      for (int c = 8; c <= 9; c++) begin
         @(negedge clk);
         avs_read      = nr;
         avs_write     = nw;
         avs_address   = na;
         avs_writedata = nd;
         hpi_data_in   = 16'h0000;
         #1;
         chk1("rec_cs_n", hpi_cs_n, 1'b1);
         chk1("rec_rd_n", hpi_rd_n, 1'b1);
         chk1("rec_wr_n", hpi_wr_n, 1'b1);
         chk1("rec_oe", hpi_data_oe, 1'b0);
         chk1("rec_wait", avs_waitrequest, nr | nw);
         chk16("rec_readdata", avs_readdata, rd_exp);
      end
      @(negedge clk);
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset_n       = 1'b0;
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      avs_address   = 2'd0;
      avs_writedata = 16'h0000;
      hpi_data_in   = 16'h0000;
`ifdef HPI_IRQ_SYNC_EN
      otg_int       = 1'b0;
`endif

      @(negedge clk);
      #1;
      chk1("rst_cs_n", hpi_cs_n, 1'b1);
      chk1("rst_rd_n", hpi_rd_n, 1'b1);
      chk1("rst_wr_n", hpi_wr_n, 1'b1);
      chk1("rst_oe", hpi_data_oe, 1'b0);
      chk16("rst_addr", {14'd0, hpi_addr}, 16'h0000);
      chk16("rst_data_out", hpi_data_out, 16'h0000);
      chk16("rst_readdata", avs_readdata, 16'h0000);
      chk1("rst_wait", avs_waitrequest, 1'b0);
`ifdef HPI_IRQ_SYNC_EN
      chk1("rst_irq", irq, 1'b0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // Write 0x1234 to the address register, then a back-to-back read presented in RECOVER.
      access(1'b0, 1'b1, 2'd2, 16'h1234, 16'h5555, 16'h0000, 16'h0000);
      gap(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000);
      access(1'b1, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF);
      gap(1'b0, 1'b0, 2'd0, 16'h0000, 16'hBEEF);

      // Read and write both high: must run as a write and leave readdata alone.
      access(1'b1, 1'b1, 2'd1, 16'h0F0F, 16'h7777, 16'hBEEF, 16'hBEEF);
      gap(1'b0, 1'b0, 2'd0, 16'h0000, 16'hBEEF);

      access(1'b1, 1'b0, 2'd1, 16'h0000, 16'h1357, 16'hBEEF, 16'h1357);
      gap(1'b0, 1'b0, 2'd0, 16'h0000, 16'h1357);

`ifdef HPI_IRQ_SYNC_EN
      otg_int = 1'b1;
      @(posedge clk);
      #1;
      chk1("irq_edge1", irq, 1'b0);
      @(posedge clk);
      #1;
      chk1("irq_edge2", irq, 1'b1);
      @(negedge clk);
      access(1'b1, 1'b0, 2'd3, 16'h0000, 16'h0001, 16'h1357, 16'h8001);
      gap(1'b0, 1'b0, 2'd0, 16'h0000, 16'h8001);
`endif

      // Reset asserted in the middle of a write strobe.
      avs_write     = 1'b1;
      avs_read      = 1'b0;
      avs_address   = 2'd1;
      avs_writedata = 16'hA5A5;
      for (int c = 1; c <= 3; c++) @(negedge clk);
      #1;
      chk1("pre_rst_wr_n", hpi_wr_n, 1'b0);
      reset_n = 1'b0;
      #1;
      chk1("mid_rst_cs_n", hpi_cs_n, 1'b1);
      chk1("mid_rst_wr_n", hpi_wr_n, 1'b1);
      chk1("mid_rst_oe", hpi_data_oe, 1'b0);
      chk16("mid_rst_readdata", avs_readdata, 16'h0000);
      avs_write = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk1("post_rst_cs_n", hpi_cs_n, 1'b1);
      chk1("post_rst_wait", avs_waitrequest, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
